// File: rtl/ram_wr_arbiter.sv
// ram_wr_arbiter
//   Round-robin arbiter that shares the single synchronous write port of a
//   3-port RAM between NUM_REQ valid/ready requesters. The winning command is
//   registered and drives write_enable/w_addr/w_data one cycle after the
//   handshake.
//   Optional feature macro: RAM_WR_ARB_SCRUB_EN. When it is defined, a
//   power-on scrub zero-fills every RAM address before arbitration starts.
module ram_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            write_enable,
   output logic [ADDR_WIDTH-1:0]           w_addr,
   output logic [DATA_WIDTH-1:0]           w_data,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic                            init_done
);

   localparam int GID_W = $clog2(NUM_REQ);
   // One extra bit so pointer + offset can exceed NUM_REQ before wrapping
   localparam int PW    = GID_W + 1;
   localparam logic [PW-1:0] NUM_REQ_P = PW'(NUM_REQ);

   // Registered command stage and round-robin pointer
   logic [GID_W-1:0]      r_rr_ptr;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [GID_W-1:0]      r_gid;

   // Arbitration results
   logic                  w_arb_en;
   logic                  w_found;
   logic [GID_W-1:0]      w_win;
   logic [PW-1:0]         w_idx;
   logic [NUM_REQ-1:0]    w_ready;
   logic [ADDR_WIDTH-1:0] w_win_addr;
   logic [DATA_WIDTH-1:0] w_win_data;
   logic [PW-1:0]         w_ptr_sum;
   logic [GID_W-1:0]      w_next_ptr;

   // Scrub control as seen by the command stage
   logic                  w_scrub_act;
   logic [ADDR_WIDTH-1:0] w_scrub_addr;

   // Next values of the command stage
   logic                  w_we_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [DATA_WIDTH-1:0] w_data_nxt;
   logic [GID_W-1:0]      w_gid_nxt;

`ifdef RAM_WR_ARB_SCRUB_EN
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_ARB  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;

   // Scrub FSM state and address counter; reset always restarts at address 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_cnt   <= {ADDR_WIDTH{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Scrub FSM next state: walk every address once, then arbitrate forever
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_INIT: begin
            w_cnt_nxt = r_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
               w_state_nxt = ST_ARB;
            end else begin
               w_state_nxt = ST_INIT;
            end
         end
         ST_ARB: begin
            w_state_nxt = ST_ARB;
            w_cnt_nxt   = r_cnt;
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_cnt_nxt   = {ADDR_WIDTH{1'b0}};
         end
      endcase
   end

   assign w_arb_en     = (r_state == ST_ARB);
   assign w_scrub_act  = (r_state == ST_INIT);
   assign w_scrub_addr = r_cnt;
`else
   // Without scrub, arbitration is live whenever reset is released
   assign w_arb_en     = rst_n;
   assign w_scrub_act  = 1'b0;
   assign w_scrub_addr = {ADDR_WIDTH{1'b0}};
`endif

   // Round-robin search: first valid requester starting at r_rr_ptr
   always_comb begin
      w_found = 1'b0;
      w_win   = {GID_W{1'b0}};
      w_idx   = {PW{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = {1'b0, r_rr_ptr} + PW'(k);
         if (w_idx >= NUM_REQ_P) begin
            w_idx = w_idx - NUM_REQ_P;
         end else begin
            w_idx = w_idx;
         end
         if (!w_found && w_arb_en && req_valid[w_idx[GID_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[GID_W-1:0];
         end else begin
            w_found = w_found;
         end
      end
   end

   // One-hot ready for the winner, plus pointer advance past the winner
   always_comb begin
      w_ready   = {NUM_REQ{1'b0}};
      w_ptr_sum = {1'b0, w_win} + {{(PW-1){1'b0}}, 1'b1};
      if (w_found) begin
         w_ready[w_win] = 1'b1;
      end else begin
         w_ready = {NUM_REQ{1'b0}};
      end
      if (w_ptr_sum >= NUM_REQ_P) begin
         w_next_ptr = {GID_W{1'b0}};
      end else begin
         w_next_ptr = w_ptr_sum[GID_W-1:0];
      end
   end

   assign w_win_addr = req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_win_data = req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];

   // Command selection: scrub write, granted request, or idle (addr/data/id hold)
   always_comb begin
      w_we_nxt   = 1'b0;
      w_addr_nxt = r_addr;
      w_data_nxt = r_data;
      w_gid_nxt  = r_gid;
      if (w_scrub_act) begin
         w_we_nxt   = 1'b1;
         w_addr_nxt = w_scrub_addr;
         w_data_nxt = {DATA_WIDTH{1'b0}};
      end else if (w_found) begin
         w_we_nxt   = 1'b1;
         w_addr_nxt = w_win_addr;
         w_data_nxt = w_win_data;
         w_gid_nxt  = w_win;
      end else begin
         w_we_nxt   = 1'b0;
      end
   end

   // Command register and round-robin pointer update on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_addr   <= {ADDR_WIDTH{1'b0}};
         r_data   <= {DATA_WIDTH{1'b0}};
         r_gid    <= {GID_W{1'b0}};
         r_rr_ptr <= {GID_W{1'b0}};
      end else begin
         r_we   <= w_we_nxt;
         r_addr <= w_addr_nxt;
         r_data <= w_data_nxt;
         r_gid  <= w_gid_nxt;
         if (w_found) begin
            r_rr_ptr <= w_next_ptr;
         end else begin
            r_rr_ptr <= r_rr_ptr;
         end
      end
   end

   assign req_ready    = w_ready;
   assign write_enable = r_we;
   assign w_addr       = r_addr;
   assign w_data       = r_data;
   assign grant_id     = r_gid;
   assign init_done    = w_arb_en;

endmodule
